// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifu_pkg;

  localparam int FETCH_STRIDE = 4;
  localparam int IFU_ADDR_W   = 32;
  localparam int IFU_DATA_W   = 32;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    BUS      = 2'd1,
    MISALIGN = 2'd2
  } fetch_err_e;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] data;
    logic [IFU_ADDR_W-1:0] addr;
    fetch_err_e            err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from storage.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_fetch_queue.sv
// Multi-outstanding AXI instruction fetch with in-order queue and redirect drop.
// Optional IFQ_BYPASS_EN: R beat goes straight to inst_* when the queue is empty.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              ID_W     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [1:0]        inst_err_o,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    fetch_err_e        err;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_next, pc_base, ar_addr_q, ar_addr_next, rsp_addr;
  logic              ar_valid_q, ar_valid_next, stale_q, stale_next;
  logic              halt_q, halt_next, mis_done_q, mis_done_next;
  logic [CW-1:0]     inflight_q, inflight_next, drop_q, drop_next, occ, occ_next;
  logic              hs, rsp, hold, bypass, q_push, q_pop, q_empty, rsp_push, mis_push;
  entry_t            rsp_entry, q_in, q_head, out_entry;
  logic              unused_addr_empty;
  logic [CW-1:0]     unused_addr_count;
  logic              unused_r_sideband;

  assign hs   = ar_valid_q && M_AXI_ARREADY;
  assign rsp  = M_AXI_RVALID;
  assign hold = ar_valid_q && !M_AXI_ARREADY;

`ifdef IFQ_BYPASS_EN
  assign bypass = q_empty && (drop_q == '0) && inst_ready_i && rsp && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_push = rsp && (drop_q == '0) && !redirect_i && !bypass;
  // Halted fetch reports its misaligned target once every stale read has drained.
  assign mis_push = halt_q && !mis_done_q && (drop_q == '0) && !redirect_i;
  assign q_push   = rsp_push || mis_push;
  assign q_pop    = !q_empty && inst_ready_i && !redirect_i;

  always_comb begin
    rsp_entry.data = M_AXI_RDATA;
    rsp_entry.addr = rsp_addr;
    rsp_entry.err  = (M_AXI_RRESP == 2'b00) ? OK : BUS;
    q_in           = rsp_entry;
    if (mis_push) begin
      q_in.data = '0;
      q_in.addr = pc_q;
      q_in.err  = MISALIGN;
    end
  end

  always_comb begin
    pc_base       = redirect_i ? redirect_addr_i : pc_q;
    halt_next     = redirect_i ? (redirect_addr_i[1:0] != 2'b00) : halt_q;
    mis_done_next = redirect_i ? 1'b0 : (mis_done_q || mis_push);
    inflight_next = inflight_q + CW'(hs) - CW'(rsp);
    // On redirect everything still outstanding afterwards is stale.
    if (redirect_i)
      drop_next = inflight_next;
    else
      drop_next = drop_q - CW'(rsp && (drop_q != '0)) + CW'(hs && stale_q);
    occ_next      = redirect_i ? '0 : (occ + CW'(q_push) - CW'(q_pop));
    ar_valid_next = hold ||
                    (!halt_next && (({1'b0, inflight_next} + {1'b0, occ_next}) < (CW+1)'(DEPTH)));
    ar_addr_next  = ar_addr_q;
    pc_next       = pc_base;
    stale_next    = hold ? (stale_q || redirect_i) : 1'b0;
    if (!hold && ar_valid_next) begin
      ar_addr_next = pc_base;
      pc_next      = pc_base + ADDR_W'(FETCH_STRIDE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ar_addr_q  <= RESET_PC;
      ar_valid_q <= 1'b0;
      stale_q    <= 1'b0;
      halt_q     <= 1'b0;
      mis_done_q <= 1'b0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_next;
      ar_addr_q  <= ar_addr_next;
      ar_valid_q <= ar_valid_next;
      stale_q    <= stale_next;
      halt_q     <= halt_next;
      mis_done_q <= mis_done_next;
      inflight_q <= inflight_next;
      drop_q     <= drop_next;
    end
  end

  ifu_fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst_n(rst_n), .flush(redirect_i),
    .push(q_push), .push_data(q_in), .pop(q_pop),
    .head(q_head), .empty(q_empty), .count(occ)
  );

  ifu_fetch_fifo #(.T(logic [ADDR_W-1:0]), .DEPTH(DEPTH)) u_addr_fifo (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .push(hs), .push_data(ar_addr_q), .pop(rsp),
    .head(rsp_addr), .empty(unused_addr_empty), .count(unused_addr_count)
  );

  assign out_entry    = bypass ? rsp_entry : q_head;
  assign inst_valid_o = !q_empty || bypass;
  assign inst_o       = inst_valid_o ? out_entry.data : '0;
  assign inst_addr_o  = inst_valid_o ? out_entry.addr : '0;
  assign inst_err_o   = inst_valid_o ? out_entry.err  : 2'd0;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = ar_addr_q;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'd2;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = 1'b1;

  assign unused_r_sideband = &{1'b0, M_AXI_RID, M_AXI_RLAST};

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch front end with multiple outstanding AXI reads. It is the next-generation replacement for the single-outstanding IF fetch path. It keeps up to `DEPTH` single-beat AXI4 read requests in flight and buffers the returned words in an in-order queue. It presents instructions to ID through a valid/ready handshake. On a redirect it discards all stale in-flight responses without stalling the AXI channel. It sits between the control unit / branch predictor redirect sources and the IF/ID pipe register.

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding reads; power of two, ≥2.
- `ADDR_W`, 32: fetch address width.
- `DATA_W`, 32: instruction word width.
- `ID_W`, 2: AXI ID width; ARID is constant 0.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `redirect_i` in 1: redirect (jump, flush, or predicted branch), single-cycle pulse.
- `redirect_addr_i` in ADDR_W: new fetch address.
- `inst_valid_o` out 1: queue head valid.
- `inst_ready_i` in 1: ID accepts the head.
- `inst_o` out DATA_W: instruction word.
- `inst_addr_o` out ADDR_W: instruction address.
- `inst_err_o` out 2: 0 = OK, 1 = bus error (RRESP≠OKAY), 2 = misaligned.
- `M_AXI_ARID` out ID_W; `M_AXI_ARADDR` out ADDR_W; `M_AXI_ARLEN` out 8 (constant 0); `M_AXI_ARSIZE` out 3 (constant 2); `M_AXI_ARBURST` out 2 (constant INCR).
- `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RID` in ID_W; `M_AXI_RDATA` in DATA_W; `M_AXI_RRESP` in 2; `M_AXI_RLAST` in 1; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.

## Operation
- State: fetch PC `pc_q`, in-flight counter `inflight` (0..DEPTH), drop counter `drop` (0..DEPTH), queue occupancy `occ`, and a `halt` flag for a misaligned target.
- Issue rule: ARVALID=1 when `!halt && inflight + occ < DEPTH` (credit scheme). Every accepted response then has a free slot, so RREADY is constant 1.
- After ARVALID rises, ARADDR stays stable until the ARREADY handshake. On handshake, `pc_q += 4` and `inflight++`.
- Responses return in order. Each response decrements `inflight`.
  - If `drop > 0`: discard the response and decrement `drop`.
  - Otherwise: push {RDATA, address, err} into the queue. The address comes from an internal issued-address FIFO of depth DEPTH.
- Pop: `inst_valid_o && inst_ready_i`.
- Redirect in cycle t:
  - Queue cleared.
  - `drop` ← in-flight requests after cycle t. This count includes an AR handshaken in cycle t and excludes a response arriving in cycle t, which is itself discarded.
  - `pc_q` ← `redirect_addr_i`.
  - A pending unaccepted AR stays asserted with its old address until handshake, and is then added to `drop`.
- Misaligned target (`redirect_addr_i[1:0]≠0`):
  - Set `halt`; no AXI request is issued.
  - Once `drop` reaches 0, enqueue one entry with err=2 and addr = target.
  - Stay halted until the next redirect.
- Bus error: the entry is enqueued with err=1 and fetch continues. Precise exception handling is downstream.
- A pop in the same cycle as a redirect is ignored; the queue is cleared anyway.

## Timing
- Reset values: ARVALID=0, ARADDR=RESET_PC, RREADY=1, `inst_valid_o`=0, `inst_o`=0, `inst_addr_o`=0, `inst_err_o`=0, all counters 0, `halt`=0.
- First ARVALID in the first cycle after `rst_n` deasserts.
- R handshake to `inst_valid_o`: 1 cycle (registered queue).
- Redirect at t: `inst_valid_o`=0 at t+1. New AR at t+1 if no AR is stuck pending.
- Steady-state throughput: 1 instruction/cycle with zero-wait AXI and `DEPTH`≥2.
- Reset asserted mid-operation clears all state immediately. The interconnect is reset in the same domain.

## Configuration
- `IFQ_BYPASS_EN` defined: when the queue is empty, `drop`=0 and `inst_ready_i`=1, an R response is presented combinationally on `inst_*` in the same cycle and is not written to the queue. Latency is 0 cycles.
- Undefined: every response goes through the queue, with the 1-cycle latency above. This mode has no combinational path from the R channel to `inst_*`.

## Structure
- `ifu_pkg` holds:
  - `fetch_err_e` enum: OK, BUS, MISALIGN.
  - `fetch_entry_t` struct: {data, addr, err}.
  - `FETCH_STRIDE` = 4.
- Sub-module `ifu_fetch_fifo`: generic synchronous FIFO with flush, parametrised by type/width and DEPTH. It is instantiated twice: the entry queue and the issued-address FIFO.

## Test plan
- ARREADY=1, 1-cycle RVALID latency, `inst_ready_i`=1, RESET_PC=0x80 → instructions at 0x80, 0x84, 0x88… one per cycle, err=0.
- `inst_ready_i`=0 for 10 cycles → exactly DEPTH (4) ARs issued, ARVALID=0 afterwards. ARVALID resumes the cycle after the first pop.
- 3 reads in flight, redirect to 0x200 → the 3 stale responses are dropped. The next output is addr 0x200 with RDATA from the 0x200 read.
- ARREADY=0 with AR(0x90) pending, redirect to 0x300 → ARADDR stays 0x90 until handshake. The 0x90 response is discarded and 0x300 is fetched next.
- Redirect to 0x302 → no AR issued, a single entry addr=0x302 err=2, then idle until a redirect to 0x400.
- RRESP=SLVERR on the read of 0x84 → entry 0x84 with err=1, and 0x88 follows normally. With `IFQ_BYPASS_EN` defined and the queue empty, `inst_valid_o` rises in the R handshake cycle.
